ip_builder: RTL and testbench
=============================

# ip_builder

Transmit-side IPv4 encapsulator: accepts a byte-wide AXI-Stream UDP datagram (UDP header + payload) from the UDP builder and prepends a 20-byte IPv4 header. The header carries a computed total length, a per-packet identification counter and a computed header checksum. The block sits between the UDP builder and the Ethernet framer, mirroring the receive-side IP parser.

## Interface
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- TTL, 8'd64, time-to-live field value.
- ID_INIT, 16'h0000, identification counter value after reset.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  UDP datagram bytes, in network order.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tlast  in  1  last byte of the datagram.
- s_axis_tuser  in  80  {src_ip[79:48], dst_ip[47:16], udp_len[15:0]}; sampled on the first beat only.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  8  IPv4 packet bytes.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tlast  out  1  last byte of the IPv4 packet.
- m_axis_tready  in  1  downstream ready.

## Operation
- States: S_IDLE, S_SUM, S_FOLD, S_HEADER, S_PAYLOAD, S_DROP.
- S_IDLE
  - s_axis_tready=0.
  - On s_axis_tvalid: latch src_ip, dst_ip and udp_len from tuser. Do not consume the byte.
  - If udp_len < 8 or udp_len > 65515, go to S_DROP; otherwise go to S_SUM.
- S_SUM (1 cycle)
  - total_len = udp_len + 20 (16-bit; cannot overflow given the range check).
  - Sum into a 20-bit accumulator the words: 0x4500, total_len, id, 0x4000, {TTL,8'h11}, src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0].
- S_FOLD (1 cycle)
  - Fold twice: s = s[15:0] + s[19:16]. Register csum = ~s[15:0].
  - Go to S_HEADER with hdr_cnt=0.
- S_HEADER
  - Header bytes 0..19, in order: 45, 00, total_len[15:8], total_len[7:0], id[15:8], id[7:0], 40, 00, TTL, 11, csum[15:8], csum[7:0], src_ip (4 bytes, MSB first), dst_ip (4 bytes, MSB first).
  - m_axis_tvalid=1, s_axis_tready=0, m_axis_tlast=0.
  - hdr_cnt advances only when m_axis_tready=1.
  - When byte 19 is accepted: id <= id+1 (wraps 0xFFFF→0x0000), then go to S_PAYLOAD.
- S_PAYLOAD
  - Combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, m_axis_tlast=s_axis_tlast, s_axis_tready=m_axis_tready.
  - On an accepted beat with tlast, go to S_IDLE.
- S_DROP
  - s_axis_tready=1, m_axis_tvalid=0.
  - Consume input until an accepted tlast, then go to S_IDLE. id does not increment.
- Header fields: DF=1, MF=0, fragment offset=0, protocol=17, DSCP/ECN=0.
- udp_len is not checked against the actual byte count. A datagram whose tlast arrives early or late is forwarded as-is.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, state=S_IDLE, id=ID_INIT, hdr_cnt=0.
- rst asserted mid-packet: return to S_IDLE on the next edge and deassert all outputs. The partial packet is abandoned; the bench must tolerate a truncated output frame.
- Latency: s_axis_tvalid first seen in S_IDLE at cycle N → header byte 0 valid at cycle N+3 (IDLE→SUM→FOLD→HEADER).
- Header with m_axis_tready held high: 20 consecutive cycles. First payload byte is available on cycle N+23 at the earliest.
- Header bytes hold their value while m_axis_tready=0 (AXI-Stream stability).
- Payload throughput: 1 byte/cycle, zero added latency.
- Back-to-back packets: S_PAYLOAD→S_IDLE costs 1 idle cycle, so minimum gap between output packets is 3 cycles.
- tuser is ignored on every beat except the one observed in S_IDLE.

## Test plan
- Basic packet:
  - Stimulus: src=C0A80001, dst=C0A800C7, udp_len=0x001C, 28-byte datagram, ID_INIT=0, TTL=64, m_axis_tready=1.
  - Response: header 45 00 00 30 00 00 40 00 40 11 B8 A4 C0 A8 00 01 C0 A8 00 C7, then the 28 input bytes unchanged; tlast on byte 48; header byte 0 exactly 3 cycles after first tvalid.
- ID sequence and wrap:
  - Stimulus: ID_INIT=16'hFFFE, send 3 valid packets.
  - Response: ID fields FFFE, FFFF, 0000; each checksum matches an independent reference model.
- Backpressure:
  - Stimulus: m_axis_tready random 50% duty, including low during header bytes 10/11 and mid-payload.
  - Response: output byte stream identical to the no-stall case; no byte changes while valid && !ready; no input consumed during the header.
- Drop on bad length:
  - Stimulus: udp_len=4, then udp_len=65516, each with a 10-byte datagram.
  - Response: both fully consumed (s_axis_tready=1), no m_axis_tvalid, id unchanged; a following valid packet carries the next id.
- Max length:
  - Stimulus: udp_len=65515.
  - Response: total_len=FFFF, checksum correct.
- Reset mid-payload:
  - Stimulus: assert rst for 1 cycle at payload byte 5, then send a new valid packet.
  - Response: outputs 0 the cycle after rst; the new packet carries id=ID_INIT and a correct header.

Source files
------------

// File: rtl/ip_builder.sv
// ip_builder: prepends a 20-byte IPv4 header to a byte-wide UDP datagram stream.
// The header carries total length, a per-packet identification counter and the
// header checksum. The checksum is built in two fixed cycles before the header goes out.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | wait for the first datagram beat; latch tuser, check udp_len
// S_SUM     | accumulate the nine 16-bit header words into a 20-bit sum
// S_FOLD    | fold the carries back in twice and register the ones-complement
// S_HEADER  | emit header bytes 0..19 under downstream flow control
// S_PAYLOAD | pass the datagram through combinationally until tlast
// S_DROP    | swallow a datagram with an illegal udp_len, no output

module ip_builder #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [7:0]  TTL        = 8'd64,
    parameter logic [15:0] ID_INIT    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [79:0]           s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SUM     = 3'd1,
        S_FOLD    = 3'd2,
        S_HEADER  = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DROP    = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] udp_len;
    logic [15:0] id;
    logic [4:0]  hdr_cnt;
    logic [19:0] acc;
    logic [15:0] csum;

    logic [15:0] total_len;
    logic [15:0] tuser_len;
    logic        len_bad;
    logic [19:0] fold1, fold2;
    logic [7:0]  hdr_byte;
    logic        hdr_last;

    // range check is done against the raw tuser value so the decision is made in S_IDLE
    assign tuser_len = s_axis_tuser[15:0];
    assign len_bad   = (tuser_len < 16'd8) || (tuser_len > 16'd65515);
    assign total_len = udp_len + 16'd20;
    assign hdr_last  = (hdr_cnt == 5'd19);

    // two end-around-carry folds are always enough for a sum of nine words
    assign fold1 = {4'h0, acc[15:0]} + {16'h0000, acc[19:16]};
    assign fold2 = {4'h0, fold1[15:0]} + {16'h0000, fold1[19:16]};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (s_axis_tvalid) state_nx = len_bad ? S_DROP : S_SUM;
            S_SUM:     state_nx = S_FOLD;
            S_FOLD:    state_nx = S_HEADER;
            S_HEADER:  if (m_axis_tready && hdr_last) state_nx = S_PAYLOAD;
            S_PAYLOAD: if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nx = S_IDLE;
            S_DROP:    if (s_axis_tvalid && s_axis_tlast) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // header context, checksum pipeline, header byte counter and id counter
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ip  <= 32'h0;
            dst_ip  <= 32'h0;
            udp_len <= 16'h0;
            id      <= ID_INIT;
            hdr_cnt <= 5'd0;
            acc     <= 20'h0;
            csum    <= 16'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_axis_tvalid) begin
                        src_ip  <= s_axis_tuser[79:48];
                        dst_ip  <= s_axis_tuser[47:16];
                        udp_len <= tuser_len;
                    end
                end
                S_SUM: begin
                    acc <= 20'h04500 + 20'(total_len) + 20'(id) + 20'h04000
                         + 20'({TTL, 8'h11})
                         + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
                         + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
                end
                S_FOLD: begin
                    csum    <= ~fold2[15:0];
                    hdr_cnt <= 5'd0;
                end
                S_HEADER: begin
                    if (m_axis_tready) begin
                        if (hdr_last) begin
                            hdr_cnt <= 5'd0;
                            id      <= id + 16'd1;
                        end else begin
                            hdr_cnt <= hdr_cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // header byte selection by position
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_cnt)
            5'd0:  hdr_byte = 8'h45;
            5'd1:  hdr_byte = 8'h00;
            5'd2:  hdr_byte = total_len[15:8];
            5'd3:  hdr_byte = total_len[7:0];
            5'd4:  hdr_byte = id[15:8];
            5'd5:  hdr_byte = id[7:0];
            5'd6:  hdr_byte = 8'h40;
            5'd7:  hdr_byte = 8'h00;
            5'd8:  hdr_byte = TTL;
            5'd9:  hdr_byte = 8'h11;
            5'd10: hdr_byte = csum[15:8];
            5'd11: hdr_byte = csum[7:0];
            5'd12: hdr_byte = src_ip[31:24];
            5'd13: hdr_byte = src_ip[23:16];
            5'd14: hdr_byte = src_ip[15:8];
            5'd15: hdr_byte = src_ip[7:0];
            5'd16: hdr_byte = dst_ip[31:24];
            5'd17: hdr_byte = dst_ip[23:16];
            5'd18: hdr_byte = dst_ip[15:8];
            5'd19: hdr_byte = dst_ip[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // stream outputs per state; payload is a zero-latency pass-through
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state)
            S_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
            end
            S_PAYLOAD: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
            end
            S_DROP: begin
                s_axis_tready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ip_builder.sv
// tb_ip_builder: randomized packets checked against a byte-level IPv4 model.
// ID_INIT is set to FFFE so the identification wrap is exercised on the third packet.

module tb_ip_builder;

    localparam logic [15:0] ID_INIT_TB = 16'hFFFE;
    localparam logic [7:0]  TTL_TB     = 8'd64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [79:0] s_tuser = 80'h0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int lat, pay_cyc, stab_err, hdr_in_err;
    bit done, drv_done, abort;
    logic [15:0] exp_id;
    logic [7:0]  pay[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];

    ip_builder #(
        .DATA_WIDTH (8),
        .TTL        (TTL_TB),
        .ID_INIT    (ID_INIT_TB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: header from the field definitions, checksum as a
    // ones-complement sum of 16-bit words folded until no carry remains.
    task automatic build_exp(input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] ulen, input logic [15:0] idv);
        logic [15:0] tl;
        logic [15:0] w[9];
        logic [15:0] ck;
        int unsigned s;
        tl = ulen + 16'd20;
        w = '{16'h4500, tl, idv, 16'h4000, {TTL_TB, 8'h11},
              src[31:16], src[15:0], dst[31:16], dst[15:0]};
        s = 0;
        foreach (w[i]) s += w[i];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        exp_q = {8'h45, 8'h00, tl[15:8], tl[7:0], idv[15:8], idv[7:0], 8'h40, 8'h00,
                 TTL_TB, 8'h11, ck[15:8], ck[7:0],
                 src[31:24], src[23:16], src[15:8], src[7:0],
                 dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
        foreach (pay[i]) exp_q.push_back(pay[i]);
    endtask

    task automatic drive_pkt(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] ulen);
        int idx = 0;
        int guard = 0;
        int n;
        bit acc;
        n = pay.size();
        drv_done = 0;
        @(posedge clk); #1;
        s_tuser  = {src, dst, ulen};
        s_tdata  = pay[0];
        s_tlast  = (n == 1);
        s_tvalid = 1'b1;
        start_cyc = cyc;
        while (idx < n && !abort && guard < 5000) begin
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            guard++;
            if (abort) break;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    s_tdata = pay[idx];
                    s_tlast = (idx == n - 1);
                    s_tuser = {$urandom, $urandom, 16'($urandom)};
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        drv_done = (idx == n);
    endtask

    task automatic mon_pkt(input int mode);
        bit prev_stall = 0;
        bit f10 = 0, f11 = 0, fmid = 0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        int guard = 0;
        int cnt;
        got.delete();
        done = 0; lat = -1; pay_cyc = -1; stab_err = 0; hdr_in_err = 0;
        m_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        while (!done && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (m_tvalid && lat < 0) lat = cyc - start_cyc;
            if (prev_stall && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stab_err++;
            if (m_tvalid && got.size() < 20 && s_tready) hdr_in_err++;
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            if (m_tvalid && m_tready) begin
                if (got.size() == 20) pay_cyc = cyc - start_cyc;
                got.push_back(m_tdata);
                if (m_tlast) done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                cnt = got.size();
                if (mode == 0) m_tready = 1'b1;
                else if (cnt == 10 && !f10) begin m_tready = 1'b0; f10 = 1; end
                else if (cnt == 11 && !f11) begin m_tready = 1'b0; f11 = 1; end
                else if (cnt == 25 && !fmid) begin m_tready = 1'b0; fmid = 1; end
                else m_tready = 1'($urandom_range(0, 1));
            end
        end
        m_tready = 1'b1;
    endtask

    task automatic test_send(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] ulen,
                             input int n, input int mode, input string name);
        int m;
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
        build_exp(src, dst, ulen, exp_id);
        abort = 0;
        fork
            drive_pkt(src, dst, ulen);
            mon_pkt(mode);
        join
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL %s timeout: got %0d bytes, want tlast", name, got.size()); end
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_err++; $display("FAIL %s length: got %0d want %0d", name, got.size(), exp_q.size()); end
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s byte %0d: got %02h want %02h", name, i, got[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL %s header latency: got %0d want 3", name, lat); end
        if (mode == 0) begin
            n_cmp++;
            if (pay_cyc !== 23) begin n_err++; $display("FAIL %s first payload cycle: got %0d want 23", name, pay_cyc); end
        end else begin
            n_cmp++;
            if (stab_err !== 0) begin n_err++; $display("FAIL %s stall stability: got %0d changes want 0", name, stab_err); end
        end
        n_cmp++;
        if (hdr_in_err !== 0) begin n_err++; $display("FAIL %s input taken in header: got %0d want 0", name, hdr_in_err); end
        n_cmp++;
        if (drv_done !== 1'b1) begin n_err++; $display("FAIL %s input consumed: got %0d want 1", name, drv_done); end
        exp_id = exp_id + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready} !== 11'h0) begin
            n_err++; $display("FAIL reset outputs: got %03h want 000", {m_tvalid, m_tlast, m_tdata, s_tready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_id = ID_INIT_TB;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready} !== 11'h0) begin
            n_err++; $display("FAIL idle outputs: got %03h want 000", {m_tvalid, m_tlast, m_tdata, s_tready});
        end
    endtask

    task automatic test_id_wrap();
        int n;
        for (int k = 0; k < 2; k++) begin
            n = $urandom_range(8, 40);
            test_send($urandom, $urandom, 16'(n), n, 0, "id_wrap");
        end
        test_send(32'hC0A80001, 32'hC0A800C7, 16'h001C, 28, 0, "basic");
    endtask

    task automatic test_backpressure();
        int n;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(12, 60);
            test_send($urandom, $urandom, 16'(n), n, 1, "backpressure");
        end
    endtask

    task automatic test_drop(input logic [15:0] ulen);
        int vcnt = 0;
        int g = 0;
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'($urandom_range(0, 255)));
        abort = 0;
        drv_done = 0;
        fork
            drive_pkt($urandom, $urandom, ulen);
            begin
                while (!drv_done && g < 200) begin
                    @(negedge clk); g++;
                    if (m_tvalid) vcnt++;
                end
                repeat (3) begin @(negedge clk); if (m_tvalid) vcnt++; end
            end
        join
        n_cmp++;
        if (drv_done !== 1'b1) begin n_err++; $display("FAIL drop %0d consumed: got %0d want 1", ulen, drv_done); end
        n_cmp++;
        if (vcnt !== 0) begin n_err++; $display("FAIL drop %0d output valid cycles: got %0d want 0", ulen, vcnt); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int g = 0;
        pay.delete();
        for (int i = 0; i < 30; i++) pay.push_back(8'($urandom_range(0, 255)));
        abort = 0;
        m_tready = 1'b1;
        fork
            drive_pkt($urandom, $urandom, 16'd30);
            begin
                while (k < 25 && g < 200) begin
                    @(negedge clk); g++;
                    if (m_tvalid && m_tready) k++;
                end
                n_cmp++;
                if (k !== 25) begin n_err++; $display("FAIL reset_mid reach byte: got %0d want 25", k); end
                @(posedge clk); #1;
                rst = 1'b1; abort = 1; s_tvalid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mid m_tvalid: got %b want 0", m_tvalid); end
                n_cmp++;
                if (m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_mid m_tlast: got %b want 0", m_tlast); end
                n_cmp++;
                if (m_tdata !== 8'h00) begin n_err++; $display("FAIL reset_mid m_tdata: got %02h want 00", m_tdata); end
                n_cmp++;
                if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_mid s_tready: got %b want 0", s_tready); end
            end
        join
        abort = 0;
        exp_id = ID_INIT_TB;
        test_send($urandom, $urandom, 16'd20, 20, 0, "after_reset");
    endtask

    initial begin
        abort = 0;
        test_reset();
        test_id_wrap();
        test_backpressure();
        test_drop(16'd4);
        test_drop(16'd65516);
        test_send($urandom, $urandom, 16'd16, 16, 0, "after_drop");
        test_send($urandom, $urandom, 16'd65515, 16, 0, "max_len");
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
